compress_sequencer: RTL
=======================

COMPRESS_SEQUENCER -- requirements
Module: compress_sequencer

Interface
REQ-001 The module SHALL have parameter PTR_W, default 16, source byte-pointer width.
REQ-002 The module SHALL have parameter OFFSET_W, default 12, copy-offset width.
REQ-003 The module SHALL have parameter LEN_W, default 4, match-length width.
REQ-004 The module SHALL have port clock, input, 1, the single clock.
REQ-005 The module SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 The module SHALL have port start, input, 1, a pulse that begins compression and is ignored unless the state is IDLE.
REQ-007 The module SHALL have port src_len, input, PTR_W, the source length in bytes, sampled when start is accepted.
REQ-008 The module SHALL have port tbl_hit, input, 1, meaning the hash-table entry is valid; it is sampled in COMPARE.
REQ-009 The module SHALL have port tbl_ptr, input, PTR_W, the previous position from the table; it is sampled in COMPARE.
REQ-010 The module SHALL have port match_len, input, LEN_W, the comparator match length; it is sampled in COMPARE.
REQ-011 The module SHALL have port out_ready, input, 1, downstream acceptance of an item or control word.
REQ-012 The module SHALL have port byte_ptr, output, PTR_W, the current source position driven to the input history and table.
REQ-013 The module SHALL have port tbl_we, output, 1, the table write strobe that stores byte_ptr at the hashed address.
REQ-014 The module SHALL have the item outputs item_valid (1), item_is_copy (1), item_len (LEN_W), item_offset (OFFSET_W) and item_byte_ptr (PTR_W).
REQ-015 The module SHALL have the control-word outputs ctrl_valid (1) and ctrl_word (16).
REQ-016 The module SHALL have the status outputs busy (1) and done (1).

Function
REQ-017 The FSM SHALL use the states IDLE, LOOKUP, COMPARE, EMIT, CTRL and DONE.
REQ-018 When start is accepted in IDLE, the module SHALL clear byte_ptr, the group count and the control word, latch src_len, and go to LOOKUP; if src_len is 0 it SHALL go directly to DONE.
REQ-019 LOOKUP SHALL last exactly 1 cycle, with byte_ptr stable for the hash and table read.
REQ-020 COMPARE SHALL last 1 cycle and compute offset = byte_ptr - tbl_ptr modulo 2^PTR_W; tbl_we SHALL pulse in this cycle only if remaining = src_len - byte_ptr is at least 3.
REQ-021 An item SHALL be a copy only if tbl_hit=1, 1 <= offset <= 2^OFFSET_W-1, match_len >= 3, match_len <= remaining and remaining >= 3; otherwise the item SHALL be a literal.
REQ-022 In EMIT, item_valid SHALL be held with all item fields stable until out_ready is sampled high.
REQ-023 item_len SHALL equal match_len for a copy and 1 for a literal; item_offset SHALL be 0 for a literal.
REQ-024 On EMIT acceptance, byte_ptr SHALL advance by item_len, the control word SHALL record bit[group count] = item_is_copy, and the group count SHALL increment.
REQ-025 After EMIT acceptance, the FSM SHALL go to CTRL if the group count reaches 16 or byte_ptr >= src_len; otherwise it SHALL go to LOOKUP.
REQ-026 In CTRL, ctrl_valid SHALL be held until out_ready, with unused bits of ctrl_word equal to 0; on acceptance, the group count and control word SHALL clear.
REQ-027 From CTRL, the FSM SHALL go to DONE if byte_ptr >= src_len; otherwise it SHALL go to LOOKUP.
REQ-028 In DONE, done SHALL be high for 1 cycle, after which the FSM SHALL return to IDLE.
REQ-029 busy SHALL be high in every state except IDLE.
REQ-030 A start pulse while busy SHALL be ignored.

Reset
REQ-031 Reset SHALL force state IDLE and set every output, the counters and the control word to 0, overriding all other inputs including a reset asserted mid-EMIT or mid-CTRL, with no partial item completing.

Configuration
REQ-032 With LZRW1_SEQ_STATS_EN defined, the module SHALL add outputs lit_count and copy_count (PTR_W each), cleared at start acceptance, each incremented on EMIT acceptance and saturating at all-ones.
REQ-033 Without LZRW1_SEQ_STATS_EN, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-034 Package lzrw1_pkg SHALL hold the state enum seq_state_t and the constants GROUP_ITEMS=16, MIN_MATCH=3 and CTRL_W=16.
REQ-035 The module SHALL contain one sub-module, ctrl_word_accum, which holds the group count and control-word shift/set logic with clear, record and full outputs.

Verification
REQ-036 The bench SHALL check: src_len=5, tbl_hit=0 always -> 5 literals at byte_ptr 0..4, then ctrl_word=0x0000, then done.
REQ-037 The bench SHALL check: src_len=20, a hit at byte_ptr=4 with tbl_ptr=0 and match_len=8 -> item 4 is a copy with offset 4 and length 8, ctrl_word bit4=1, and byte_ptr goes from 4 to 12.
REQ-038 The bench SHALL check: src_len=40, no hits -> ctrl_valid after the 16th and 32nd items and after the 40th item; the last ctrl_word is 0x0000 with only 8 items recorded.
REQ-039 The bench SHALL check: match_len=6 while remaining=4 -> literal emitted; remaining=2 -> tbl_we stays low.
REQ-040 The bench SHALL check: out_ready held low for 5 cycles in EMIT -> item fields stable and byte_ptr unchanged; a start pulse during this stall is ignored.
REQ-041 The bench SHALL check: reset asserted mid-CTRL -> next cycle IDLE with all outputs 0; a new start then compresses from byte_ptr 0.

Source files
------------

// File: rtl/lzrw1_pkg.sv
// rtl/lzrw1_pkg.sv - shared state type and group constants for the LZRW1 compress sequencer
package lzrw1_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    COMPARE,
    EMIT,
    CTRL,
    DONE
  } seq_state_t;

  localparam int GROUP_ITEMS = 16;
  localparam int MIN_MATCH   = 3;
  localparam int CTRL_W      = 16;
  localparam int GROUP_CNT_W = $clog2(GROUP_ITEMS) + 1;

endpackage

// File: rtl/compress_sequencer_ctrl_word_accum.sv
// rtl/compress_sequencer_ctrl_word_accum.sv - group item counter and copy/literal control-word builder
module ctrl_word_accum
  import lzrw1_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              record,
  input  logic              bit_in,
  output logic [CTRL_W-1:0] word,
  output logic              full
);

  logic [GROUP_CNT_W-1:0] count_q, count_d;
  logic [CTRL_W-1:0]      word_q, word_d;

  always_comb begin
    count_d = count_q;
    word_d  = word_q;
    if (clear) begin
      count_d = '0;
      word_d  = '0;
    end else if (record) begin
      word_d[count_q[GROUP_CNT_W-2:0]] = bit_in;
      count_d = count_q + GROUP_CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
      word_q  <= '0;
    end else begin
      count_q <= count_d;
      word_q  <= word_d;
    end
  end

  assign word = word_q;
  // High on the record that fills the last slot of the group.
  assign full = record && (count_q == GROUP_CNT_W'(GROUP_ITEMS - 1));

endmodule

// File: rtl/compress_sequencer.sv
// rtl/compress_sequencer.sv - LZRW1 item/control-word sequencer; LZRW1_SEQ_STATS_EN adds literal/copy counters
module compress_sequencer
  import lzrw1_pkg::*;
#(
  parameter int PTR_W    = 16,
  parameter int OFFSET_W = 12,
  parameter int LEN_W    = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [PTR_W-1:0]    src_len,
  input  logic                tbl_hit,
  input  logic [PTR_W-1:0]    tbl_ptr,
  input  logic [LEN_W-1:0]    match_len,
  input  logic                out_ready,
  output logic [PTR_W-1:0]    byte_ptr,
  output logic                tbl_we,
  output logic                item_valid,
  output logic                item_is_copy,
  output logic [LEN_W-1:0]    item_len,
  output logic [OFFSET_W-1:0] item_offset,
  output logic [PTR_W-1:0]    item_byte_ptr,
  output logic                ctrl_valid,
  output logic [CTRL_W-1:0]   ctrl_word,
  output logic                busy,
  output logic                done
`ifdef LZRW1_SEQ_STATS_EN
  ,
  output logic [PTR_W-1:0]    lit_count,
  output logic [PTR_W-1:0]    copy_count
`endif
);

  seq_state_t          state_q, state_d;
  logic [PTR_W-1:0]    byte_ptr_q, byte_ptr_d;
  logic [PTR_W-1:0]    src_len_q, src_len_d;
  logic [PTR_W-1:0]    item_byte_ptr_q, item_byte_ptr_d;
  logic                item_valid_q, item_valid_d;
  logic                item_is_copy_q, item_is_copy_d;
  logic [LEN_W-1:0]    item_len_q, item_len_d;
  logic [OFFSET_W-1:0] item_offset_q, item_offset_d;
  logic                ctrl_valid_q, ctrl_valid_d;
  logic                tbl_we_q, tbl_we_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
`ifdef LZRW1_SEQ_STATS_EN
  logic [PTR_W-1:0]    lit_count_q, lit_count_d;
  logic [PTR_W-1:0]    copy_count_q, copy_count_d;
`endif

  logic [PTR_W-1:0] remaining;
  logic [PTR_W-1:0] offset_full;
  logic [PTR_W-1:0] next_ptr;
  logic             is_copy;
  logic             acc_clear, acc_record, acc_full;

  assign remaining   = src_len_q - byte_ptr_q;
  assign offset_full = byte_ptr_q - tbl_ptr;
  assign next_ptr    = byte_ptr_q + PTR_W'(item_len_q);

  // Offset must be nonzero and fit in OFFSET_W bits; the match must not run past the source.
  assign is_copy = tbl_hit
                && (offset_full != '0)
                && ((offset_full >> OFFSET_W) == '0)
                && (match_len >= LEN_W'(MIN_MATCH))
                && (PTR_W'(match_len) <= remaining)
                && (remaining >= PTR_W'(MIN_MATCH));

  ctrl_word_accum u_accum (
    .clock  (clock),
    .reset  (reset),
    .clear  (acc_clear),
    .record (acc_record),
    .bit_in (item_is_copy_q),
    .word   (ctrl_word),
    .full   (acc_full)
  );

  always_comb begin
    state_d         = state_q;
    byte_ptr_d      = byte_ptr_q;
    src_len_d       = src_len_q;
    item_byte_ptr_d = item_byte_ptr_q;
    item_valid_d    = item_valid_q;
    item_is_copy_d  = item_is_copy_q;
    item_len_d      = item_len_q;
    item_offset_d   = item_offset_q;
    ctrl_valid_d    = ctrl_valid_q;
    tbl_we_d        = 1'b0;
    acc_clear       = 1'b0;
    acc_record      = 1'b0;
`ifdef LZRW1_SEQ_STATS_EN
    lit_count_d     = lit_count_q;
    copy_count_d    = copy_count_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          byte_ptr_d = '0;
          src_len_d  = src_len;
          acc_clear  = 1'b1;
`ifdef LZRW1_SEQ_STATS_EN
          lit_count_d  = '0;
          copy_count_d = '0;
`endif
          state_d    = (src_len == '0) ? DONE : LOOKUP;
        end
      end
      LOOKUP: begin
        // Registered so the strobe lands in the COMPARE cycle.
        tbl_we_d = (remaining >= PTR_W'(MIN_MATCH));
        state_d  = COMPARE;
      end
      COMPARE: begin
        item_valid_d    = 1'b1;
        item_is_copy_d  = is_copy;
        item_len_d      = is_copy ? match_len : LEN_W'(1);
        item_offset_d   = is_copy ? offset_full[OFFSET_W-1:0] : '0;
        item_byte_ptr_d = byte_ptr_q;
        state_d         = EMIT;
      end
      EMIT: begin
        if (out_ready) begin
          item_valid_d = 1'b0;
          acc_record   = 1'b1;
          byte_ptr_d   = next_ptr;
`ifdef LZRW1_SEQ_STATS_EN
          if (item_is_copy_q) begin
            if (copy_count_q != '1) copy_count_d = copy_count_q + PTR_W'(1);
          end else begin
            if (lit_count_q != '1) lit_count_d = lit_count_q + PTR_W'(1);
          end
`endif
          if (acc_full || (next_ptr >= src_len_q)) begin
            ctrl_valid_d = 1'b1;
            state_d      = CTRL;
          end else begin
            state_d = LOOKUP;
          end
        end
      end
      CTRL: begin
        if (out_ready) begin
          ctrl_valid_d = 1'b0;
          acc_clear    = 1'b1;
          state_d      = (byte_ptr_q >= src_len_q) ? DONE : LOOKUP;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      byte_ptr_q      <= '0;
      src_len_q       <= '0;
      item_byte_ptr_q <= '0;
      item_valid_q    <= 1'b0;
      item_is_copy_q  <= 1'b0;
      item_len_q      <= '0;
      item_offset_q   <= '0;
      ctrl_valid_q    <= 1'b0;
      tbl_we_q        <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
`ifdef LZRW1_SEQ_STATS_EN
      lit_count_q     <= '0;
      copy_count_q    <= '0;
`endif
    end else begin
      state_q         <= state_d;
      byte_ptr_q      <= byte_ptr_d;
      src_len_q       <= src_len_d;
      item_byte_ptr_q <= item_byte_ptr_d;
      item_valid_q    <= item_valid_d;
      item_is_copy_q  <= item_is_copy_d;
      item_len_q      <= item_len_d;
      item_offset_q   <= item_offset_d;
      ctrl_valid_q    <= ctrl_valid_d;
      tbl_we_q        <= tbl_we_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
`ifdef LZRW1_SEQ_STATS_EN
      lit_count_q     <= lit_count_d;
      copy_count_q    <= copy_count_d;
`endif
    end
  end

  assign byte_ptr      = byte_ptr_q;
  assign tbl_we        = tbl_we_q;
  assign item_valid    = item_valid_q;
  assign item_is_copy  = item_is_copy_q;
  assign item_len      = item_len_q;
  assign item_offset   = item_offset_q;
  assign item_byte_ptr = item_byte_ptr_q;
  assign ctrl_valid    = ctrl_valid_q;
  assign busy          = busy_q;
  assign done          = done_q;
`ifdef LZRW1_SEQ_STATS_EN
  assign lit_count     = lit_count_q;
  assign copy_count    = copy_count_q;
`endif

endmodule
